// File: rtl/pebble_mc_core_if.sv
// pebble_mc_core_if: data-memory request/acknowledge bus of the Pebble core.
//   dmem_req   core -> mem  request, held until ack
//   dmem_we    core -> mem  1 = store, 0 = load
//   dmem_addr  core -> mem  address, stable while req
//   dmem_wdata core -> mem  store data, stable while req
//   dmem_rdata mem  -> core load data, valid in the ack cycle
//   dmem_ack   mem  -> core one-cycle completion pulse
interface pebble_mc_core_if #(
    parameter int DW = 8
) ();
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    input  dmem_rdata, dmem_ack);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    output dmem_rdata, dmem_ack);
endinterface

// File: rtl/pebble_mc_core.sv
// pebble_mc_core: multi-cycle core for the 9-bit Pebble ISA.
// Runs IDLE -> FETCH -> EXEC [-> MEM] -> FETCH ... -> HALT, with a start/done
// run handshake and a saturating count of busy (FETCH/EXEC/MEM) cycles.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   start       level-sampled run request (honoured in IDLE/HALT only)
//   done        high while halted
//   imem_addr   instruction address (= PC); imem_data sampled in FETCH
//   dmem        data-memory req/ack bus (master side)
//   cycles      busy cycles of the current run, saturating at all-ones
module pebble_mc_core #(
    parameter int DW  = 8,
    parameter int PCW = 10,
    parameter int CW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             done,
    output logic [PCW-1:0]   imem_addr,
    input  logic [8:0]       imem_data,
    pebble_mc_core_if.master dmem,
    output logic [CW-1:0]    cycles
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t             state;
    logic [PCW-1:0]     pc;
    logic [8:0]         ir;
    logic [3:0][DW-1:0] rf;
    logic [DW-1:0]      rs1_val;
    logic [DW-1:0]      rs2_val;
    logic [DW-1:0]      alu_res;
    logic [PCW-1:0]     pc_inc;
    logic               busy;

    assign imem_addr = pc;
    // ir[3:2]/ir[1:0] are the ALU operands and also the branch compare pair.
    assign rs1_val   = rf[ir[3:2]];
    assign rs2_val   = rf[ir[1:0]];
    assign pc_inc    = pc + PCW'(1);
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);

    always_comb begin
        alu_res = '0;
        case (ir[6:4])
            3'd0: alu_res = rs1_val + rs2_val;
            3'd1: alu_res = rs1_val - rs2_val;
            3'd2: alu_res = rs1_val & rs2_val;
            3'd3: alu_res = rs1_val | rs2_val;
            3'd4: alu_res = rs1_val ^ rs2_val;
            3'd5: alu_res = rs1_val << 1;
            3'd6: alu_res = rs1_val >> 1;
            3'd7: alu_res = DW'(rs1_val < rs2_val);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            pc              <= '0;
            ir              <= '0;
            rf              <= '0;
            cycles          <= '0;
            done            <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
        end else begin
            if (busy && !(&cycles))
                cycles <= cycles + CW'(1);

            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        cycles <= '0;
                        done   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (ir[8:7])
                        2'b00: begin
                            rf[ir[3:2]] <= alu_res;
                            pc          <= pc_inc;
                            state       <= S_FETCH;
                        end
                        2'b01: begin
                            rf[ir[6:5]] <= DW'(ir[4:0]);
                            pc          <= pc_inc;
                            state       <= S_FETCH;
                        end
                        2'b10: begin
                            // Bus fields are registered here so they stay put
                            // for however long the memory takes to ack.
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= ~ir[6];
                            dmem.dmem_addr  <= rf[ir[3:2]];
                            dmem.dmem_wdata <= rf[ir[5:4]];
                            state           <= S_MEM;
                        end
                        2'b11: begin
                            if (ir[6]) begin
                                done  <= 1'b1;
                                state <= S_HALT;
                            end else begin
                                pc    <= (rs1_val == rs2_val) ? PCW'(rf[ir[5:4]]) : pc_inc;
                                state <= S_FETCH;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem.dmem_ack) begin
                        if (!dmem.dmem_we)
                            rf[ir[5:4]] <= dmem.dmem_rdata;
                        dmem.dmem_req <= 1'b0;
                        pc            <= pc_inc;
                        state         <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pebble_mc_core.sv
module tb_pebble_mc_core;
    localparam int DW  = 8;
    localparam int PCW = 6;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           done;
    logic [PCW-1:0] imem_addr;
    logic [8:0]     imem_data;
    logic [CW-1:0]  cycles;

    pebble_mc_core_if #(.DW(DW)) mif ();

    pebble_mc_core #(.DW(DW), .PCW(PCW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem(mif.master), .cycles(cycles)
    );

    always #5 clk = ~clk;

    logic [8:0] imem [64];
    assign imem_data = imem[imem_addr];

    logic [7:0] dmem [256];
    int  mem_wait;
    bit  spurious;
    int  tests;
    int  fails;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;
    txn_t sb[$];

    typedef struct {
        logic [2:0] f;
        logic [4:0] a;
        logic [4:0] b;
        logic [7:0] res;
    } alu_vec_t;
    alu_vec_t vt[11];

    localparam logic [8:0] HALT = 9'b11_1_000000;

    function automatic logic [8:0] op_r(input logic [2:0] f, input logic [1:0] rd, input logic [1:0] rs);
        return {2'b00, f, rd, rs};
    endfunction
    function automatic logic [8:0] li(input logic [1:0] rd, input logic [4:0] imm);
        return {2'b01, rd, imm};
    endfunction
    function automatic logic [8:0] st(input logic [1:0] d, input logic [1:0] a);
        return {2'b10, 1'b0, d, a, 2'b00};
    endfunction
    function automatic logic [8:0] ld(input logic [1:0] d, input logic [1:0] a);
        return {2'b10, 1'b1, d, a, 2'b00};
    endfunction
    function automatic logic [8:0] beq(input logic [1:0] t, input logic [1:0] a, input logic [1:0] b);
        return {2'b11, 1'b0, t, a, b};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic exp_st(input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.we = 1'b1; t.addr = a; t.data = d;
        sb.push_back(t);
    endtask
    task automatic exp_ld(input logic [7:0] a);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.data = '0;
        sb.push_back(t);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = HALT;
    endtask

    // Memory model: acks after mem_wait extra cycles, checks the request stays
    // stable, and checks each completed transaction against the scoreboard.
    task automatic responder();
        int         wcnt;
        bit         in_req;
        logic       cap_we;
        logic [7:0] cap_addr;
        logic [7:0] cap_wdata;
        txn_t       t;
        wcnt = 0; in_req = 0;
        forever begin
            @(negedge clk);
            mif.dmem_ack = 1'b0;
            if (!reset) begin
                wcnt = 0; in_req = 0;
            end else if (mif.dmem_req) begin
                if (!in_req) begin
                    in_req = 1; wcnt = 0;
                    cap_we = mif.dmem_we; cap_addr = mif.dmem_addr; cap_wdata = mif.dmem_wdata;
                end else begin
                    chk("req_addr_stable", mif.dmem_addr, cap_addr);
                    chk("req_we_stable", mif.dmem_we, cap_we);
                    if (cap_we) chk("req_wdata_stable", mif.dmem_wdata, cap_wdata);
                end
                if (wcnt == mem_wait) begin
                    mif.dmem_ack = 1'b1;
                    if (cap_we) dmem[cap_addr] = cap_wdata;
                    else        mif.dmem_rdata = dmem[cap_addr];
                    in_req = 0;
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_txn", 1, 0);
                    end else begin
                        t = sb.pop_front();
                        chk("sb_we", cap_we, t.we);
                        chk("sb_addr", cap_addr, t.addr);
                        if (t.we) chk("sb_data", cap_wdata, t.data);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                in_req = 0; wcnt = 0;
                if (spurious) begin
                    mif.dmem_ack   = 1'b1;
                    mif.dmem_rdata = 8'h55;
                end
            end
        end
    endtask

    task automatic run(input bit hold, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        lat = 0;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (!done) chk("run_timeout", lat, -1);
    endtask

    task automatic prog_store_aa();
        clear_imem();
        imem[0] = li(1, 5'd21);
        imem[1] = op_r(5, 1, 0);
        imem[2] = op_r(5, 1, 0);
        imem[3] = op_r(5, 1, 0);
        imem[4] = li(3, 5'd2);
        imem[5] = op_r(3, 1, 3);
        imem[6] = li(2, 5'd7);
        imem[7] = st(1, 2);
        imem[8] = HALT;
    endtask

    initial begin
        int lat;
        int waits[3];
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0;
        mem_wait = 0; spurious = 0;
        mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        waits[0] = 0; waits[1] = 1; waits[2] = 4;

        vt[0]  = '{3'd0, 5'd31, 5'd31, 8'h3E};
        vt[1]  = '{3'd1, 5'd3,  5'd5,  8'hFE};
        vt[2]  = '{3'd1, 5'd0,  5'd1,  8'hFF};
        vt[3]  = '{3'd2, 5'h1C, 5'h0F, 8'h0C};
        vt[4]  = '{3'd3, 5'h10, 5'h05, 8'h15};
        vt[5]  = '{3'd4, 5'h1F, 5'h0A, 8'h15};
        vt[6]  = '{3'd5, 5'h1F, 5'd7,  8'h3E};
        vt[7]  = '{3'd6, 5'h1F, 5'd7,  8'h0F};
        vt[8]  = '{3'd7, 5'd3,  5'd5,  8'h01};
        vt[9]  = '{3'd7, 5'd5,  5'd3,  8'h00};
        vt[10] = '{3'd7, 5'd7,  5'd7,  8'h00};

        fork responder(); join_none

        clear_imem();
        repeat (3) @(posedge clk); #1;
        chk("rst_done", done, 0);
        chk("rst_req", mif.dmem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_cycles", cycles, 0);
        @(negedge clk) reset = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_cycles", cycles, 0);
        chk("idle_imem_addr", imem_addr, 0);
        chk("idle_req", mif.dmem_req, 0);

        // Spec ALU program: timing and cycle count.
        clear_imem();
        imem[0] = li(0, 5'd5);
        imem[1] = li(1, 5'd3);
        imem[2] = op_r(0, 0, 1);
        imem[3] = op_r(1, 0, 1);
        imem[4] = HALT;
        run(0, lat);
        chk("alu_prog_latency", lat, 10);
        chk("alu_prog_cycles", cycles, 10);
        repeat (3) @(posedge clk); #1;
        chk("done_held", done, 1);
        chk("cycles_held", cycles, 10);

        // Same program with stores to expose r0 = 8 then 5.
        clear_imem();
        imem[0] = li(0, 5'd5);
        imem[1] = li(1, 5'd3);
        imem[2] = li(2, 5'd0);
        imem[3] = op_r(0, 0, 1);
        imem[4] = st(0, 2);
        imem[5] = op_r(1, 0, 1);
        imem[6] = st(0, 2);
        imem[7] = HALT;
        exp_st(8'd0, 8'd8);
        exp_st(8'd0, 8'd5);
        run(0, lat);
        chk("alu_st_latency", lat, 18);

        // Table-driven ALU vectors.
        for (int i = 0; i < 11; i++) begin
            clear_imem();
            imem[0] = li(0, 5'd16);
            imem[1] = li(1, vt[i].a);
            imem[2] = li(2, vt[i].b);
            imem[3] = op_r(vt[i].f, 1, 2);
            imem[4] = st(1, 0);
            imem[5] = HALT;
            exp_st(8'd16, vt[i].res);
            run(0, lat);
            chk("alu_vec_latency", lat, 13);
        end

        // Wrap mod 2^DW.
        clear_imem();
        imem[0] = li(0, 5'd31);
        imem[1] = li(1, 5'd20);
        imem[2] = op_r(5, 0, 0);
        imem[3] = op_r(5, 0, 0);
        imem[4] = op_r(5, 0, 0);
        imem[5] = st(0, 1);
        imem[6] = op_r(0, 0, 0);
        imem[7] = st(0, 1);
        imem[8] = HALT;
        exp_st(8'd20, 8'hF8);
        exp_st(8'd20, 8'hF0);
        run(0, lat);
        chk("wrap_latency", lat, 20);

        // Store with 0, 1 and 4 wait cycles.
        for (int k = 0; k < 3; k++) begin
            mem_wait = waits[k];
            dmem[7] = 8'h00;
            prog_store_aa();
            exp_st(8'd7, 8'hAA);
            run(0, lat);
            chk("store_latency", lat, 19 + waits[k]);
            chk("store_mem_data", dmem[7], 8'hAA);
        end

        // Load back (r2 = 7 retained), spurious acks outside MEM.
        clear_imem();
        imem[0] = ld(3, 2);
        imem[1] = li(0, 5'd8);
        imem[2] = st(3, 0);
        imem[3] = HALT;
        mem_wait = 1; spurious = 1;
        exp_ld(8'd7);
        exp_st(8'd8, 8'hAA);
        run(0, lat);
        spurious = 0;
        chk("load_latency", lat, 12);

        // Branch taken then not taken.
        mem_wait = 0;
        clear_imem();
        imem[0]  = li(0, 5'd5);
        imem[1]  = li(1, 5'd5);
        imem[2]  = li(2, 5'd6);
        imem[3]  = beq(2, 0, 1);
        imem[4]  = li(3, 5'd1);
        imem[5]  = HALT;
        imem[6]  = li(3, 5'd9);
        imem[7]  = li(2, 5'd0);
        imem[8]  = beq(2, 0, 3);
        imem[9]  = li(0, 5'd30);
        imem[10] = st(3, 0);
        imem[11] = HALT;
        exp_st(8'd30, 8'd9);
        run(0, lat);
        chk("branch_latency", lat, 21);

        // Restart from HALT: PC=0, registers retained (r3=9, r0=30).
        clear_imem();
        imem[0] = st(3, 0);
        imem[1] = HALT;
        exp_st(8'd30, 8'd9);
        run(0, lat);
        chk("restart_latency", lat, 5);

        // Branch target 0xFF truncated to PCW=6.
        clear_imem();
        imem[0] = li(0, 5'd31);
        imem[1] = op_r(5, 0, 0);
        imem[2] = op_r(5, 0, 0);
        imem[3] = op_r(5, 0, 0);
        imem[4] = li(1, 5'd7);
        imem[5] = op_r(3, 0, 1);
        imem[6] = beq(0, 2, 2);
        run(0, lat);
        chk("br_trunc_latency", lat, 16);
        chk("br_trunc_pc", imem_addr, 63);

        // start held high through a 4-wait store is ignored.
        mem_wait = 4;
        prog_store_aa();
        exp_st(8'd7, 8'hAA);
        run(1, lat);
        chk("start_in_mem_latency", lat, 23);
        mem_wait = 0;

        // Saturating cycle counter.
        clear_imem();
        for (int i = 0; i < 20; i++) imem[i] = li(0, 5'd1);
        run(0, lat);
        chk("sat_latency", lat, 42);
        chk("sat_cycles", cycles, 31);

        // Reset while a store waits in MEM.
        mem_wait = 50;
        clear_imem();
        imem[0] = li(0, 5'd3);
        imem[1] = st(0, 0);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!mif.dmem_req && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mid_mem_req_seen", mif.dmem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", mif.dmem_req, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_imem_addr", imem_addr, 0);
        chk("async_rst_cycles", cycles, 0);
        @(negedge clk) reset = 1'b1;
        mem_wait = 0;
        repeat (4) @(posedge clk); #1;
        chk("post_rst_idle_cycles", cycles, 0);
        chk("post_rst_idle_addr", imem_addr, 0);
        chk("post_rst_idle_req", mif.dmem_req, 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
